// File: rtl/i2s_ws_ctrl.sv
// Purpose : run/stop and frame-boundary config control for an I2S word-select generator.
// Latency : ws_en_o rises one sck_i cycle after cfg_en_i; config changes take effect at frame boundaries.
// Backpres: none; a second update before the first is applied overwrites it and sets upd_ovr_o.
//
// Ports:
//   sck_i, rstn_i                  serial clock (rising edge), async active-low reset
//   cfg_en_i                       run request (level)
//   cfg_update_i                   pulse: load cfg_data_size_i / cfg_word_num_i
//   cfg_data_size_i                bits per word minus 1
//   cfg_word_num_i                 words per frame minus 1 (8..15 clamp to 7)
//   cfg_clr_i                      pulse: clear upd_ovr_o
//   ws_en_o, ws_data_size_o,
//   ws_word_num_o                  enable and active config to the WS generator
//   frame_start_o                  high in the first bit cycle of every frame
//   busy_o                         update pending or stop draining
//   upd_ovr_o                      sticky: pending update was overwritten
//   frame_cnt_o                    completed frames (only with I2S_WS_CTRL_FRAME_CNT_EN)
//
// Build option: define I2S_WS_CTRL_FRAME_CNT_EN to include the completed-frame counter.

module i2s_ws_ctrl (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic        cfg_update_i,
    input  logic [4:0]  cfg_data_size_i,
    input  logic [3:0]  cfg_word_num_i,
    input  logic        cfg_clr_i,
    output logic        ws_en_o,
    output logic [4:0]  ws_data_size_o,
    output logic [3:0]  ws_word_num_o,
    output logic        frame_start_o,
    output logic        busy_o,
    output logic        upd_ovr_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  ds_sh_q, ds_sh_d;
    logic [2:0]  wn_sh_q, wn_sh_d;
    logic [4:0]  ds_act_q, ds_act_d;
    logic [2:0]  wn_act_q, wn_act_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  word_cnt_q, word_cnt_d;

    logic        ws_en;
    logic        bit_last;
    logic        word_last;
    logic        last;
    logic        apply;
    logic        ovr_set;
    logic [2:0]  wn_clamped;

    // Word counts above 8 are not supported by the generator; saturate at 8 words.
    assign wn_clamped = cfg_word_num_i[3] ? 3'd7 : cfg_word_num_i[2:0];

    assign ws_en     = (state_q != ST_IDLE);
    assign bit_last  = (bit_cnt_q == ds_act_q);
    assign word_last = (word_cnt_q == wn_act_q);
    assign last      = ws_en && bit_last && word_last;
    assign apply     = last && pend_q;

    // State register and all config/counter flops.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            ds_sh_q    <= '0;
            wn_sh_q    <= '0;
            ds_act_q   <= '0;
            wn_act_q   <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ds_sh_q    <= ds_sh_d;
            wn_sh_q    <= wn_sh_d;
            ds_act_q   <= ds_act_d;
            wn_act_q   <= wn_act_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next-state logic. Stopping always waits for the frame to finish, so
    // every exit to IDLE happens on a last edge and the counters land on 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!cfg_en_i) state_d = last ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cfg_en_i)  state_d = ST_RUN;
                else if (last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mirror of the generator's bit/word counters, using the active config.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (ws_en) begin
            if (bit_last) begin
                bit_cnt_d  = '0;
                word_cnt_d = word_last ? 3'd0 : word_cnt_q + 3'd1;
            end else begin
                bit_cnt_d  = bit_cnt_q + 5'd1;
            end
        end
    end

    // Shadow/active config. While idle nothing is framing, so an update goes
    // straight to the generator. While running, updates wait in the shadow
    // until the last bit of the current frame; the old shadow is applied
    // before a same-edge update overwrites it, so that update stays pending.
    always_comb begin
        ds_sh_d  = ds_sh_q;
        wn_sh_d  = wn_sh_q;
        ds_act_d = ds_act_q;
        wn_act_d = wn_act_q;
        pend_d   = pend_q;
        ovr_set  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cfg_update_i) begin
                ds_sh_d  = cfg_data_size_i;
                wn_sh_d  = wn_clamped;
                ds_act_d = cfg_data_size_i;
                wn_act_d = wn_clamped;
            end
        end else begin
            if (apply) begin
                ds_act_d = ds_sh_q;
                wn_act_d = wn_sh_q;
                pend_d   = 1'b0;
            end
            if (cfg_update_i) begin
                ds_sh_d = cfg_data_size_i;
                wn_sh_d = wn_clamped;
                pend_d  = 1'b1;
                if (pend_q && !apply) ovr_set = 1'b1;
            end
        end
        // A new overwrite takes priority over a clear on the same edge.
        ovr_d = ovr_set | (ovr_q & ~cfg_clr_i);
    end

`ifdef I2S_WS_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt_q <= '0;
        end else if (last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign frame_cnt_o = '0;
`endif

    assign ws_en_o        = ws_en;
    assign ws_data_size_o = ds_act_q;
    assign ws_word_num_o  = {1'b0, wn_act_q};
    assign frame_start_o  = ws_en && (bit_cnt_q == 5'd0) && (word_cnt_q == 3'd0);
    assign busy_o         = pend_q || (state_q == ST_DRAIN);
    assign upd_ovr_o      = ovr_q;

endmodule

// File: tb/tb_i2s_ws_ctrl.sv
module tb_i2s_ws_ctrl;

    logic        sck_i = 1'b0;
    logic        rstn_i;
    logic        cfg_en_i;
    logic        cfg_update_i;
    logic [4:0]  cfg_data_size_i;
    logic [3:0]  cfg_word_num_i;
    logic        cfg_clr_i;
    logic        ws_en_o;
    logic [4:0]  ws_data_size_o;
    logic [3:0]  ws_word_num_o;
    logic        frame_start_o;
    logic        busy_o;
    logic        upd_ovr_o;
    logic [15:0] frame_cnt_o;

    i2s_ws_ctrl dut (
        .sck_i          (sck_i),
        .rstn_i         (rstn_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_update_i   (cfg_update_i),
        .cfg_data_size_i(cfg_data_size_i),
        .cfg_word_num_i (cfg_word_num_i),
        .cfg_clr_i      (cfg_clr_i),
        .ws_en_o        (ws_en_o),
        .ws_data_size_o (ws_data_size_o),
        .ws_word_num_o  (ws_word_num_o),
        .frame_start_o  (frame_start_o),
        .busy_o         (busy_o),
        .upd_ovr_o      (upd_ovr_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always #5 sck_i = ~sck_i;

    // Cycle index: number of rising edges seen so far.
    int cyc = 0;
    always @(posedge sck_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] ds;
        logic [3:0] wn;
        logic       busy;
    } fs_exp_t;

    fs_exp_t fs_q[$];
    int      fall_q[$];
    bit      fs_mon_en = 1'b1;
    logic    ws_en_prev = 1'b0;
    fs_exp_t e;
    int      fall_exp;

`ifdef I2S_WS_CTRL_FRAME_CNT_EN
    localparam int NFRM   = 70000;
    localparam int FC_EXP = 4464;
`else
    localparam int NFRM   = 20;
    localparam int FC_EXP = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        if (cyc > t) begin
            n_checks++;
            n_errors++;
            $display("FAIL schedule: cycle %0d already past %0d", cyc, t);
        end
        while (cyc < t) @(negedge sck_i);
    endtask

    task automatic push_fs(input int c, input logic [4:0] ds, input logic [3:0] wn);
        fs_exp_t x;
        x.cyc = c; x.ds = ds; x.wn = wn; x.busy = 1'b0;
        fs_q.push_back(x);
    endtask

    // Monitor: compares every frame start and every ws_en_o fall against the queues.
    always @(negedge sck_i) begin
        if (fs_mon_en && frame_start_o) begin
            if (fs_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fs_unexpected at cycle %0d: frame_start_o=1, expected none", cyc);
            end else begin
                e = fs_q.pop_front();
                chk("fs_cycle", cyc, e.cyc);
                chk("fs_ds", 32'(ws_data_size_o), 32'(e.ds));
                chk("fs_wn", 32'(ws_word_num_o), 32'(e.wn));
                chk("fs_busy", 32'(busy_o), 32'(e.busy));
            end
        end
        if (ws_en_prev && !ws_en_o) begin
            if (fall_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fall_unexpected at cycle %0d: ws_en_o fell, expected none", cyc);
            end else begin
                fall_exp = fall_q.pop_front();
                chk("fall_cycle", cyc, fall_exp);
            end
        end
        ws_en_prev = ws_en_o;
    end

    task automatic upd(input logic [4:0] ds, input logic [3:0] wn);
        cfg_update_i    = 1'b1;
        cfg_data_size_i = ds;
        cfg_word_num_i  = wn;
    endtask

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_update_i = 1'b0;
        cfg_data_size_i = '0; cfg_word_num_i = '0; cfg_clr_i = 1'b0;

        // Reset state
        wait_cyc(1);
        chk("rst_ws_en", 32'(ws_en_o), 0);
        chk("rst_ds", 32'(ws_data_size_o), 0);
        chk("rst_wn", 32'(ws_word_num_o), 0);
        chk("rst_fs", 32'(frame_start_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ovr", 32'(upd_ovr_o), 0);
        chk("rst_fcnt", 32'(frame_cnt_o), 0);
        wait_cyc(2);
        rstn_i = 1'b1;

        // Start with same-edge update ds=15 wn=1: 32-cycle frames
        wait_cyc(5);
        upd(5'd15, 4'd1);
        cfg_en_i = 1'b1;
        push_fs(6, 5'd15, 4'd1);
        push_fs(38, 5'd15, 4'd1);
        push_fs(70, 5'd15, 4'd1);
        wait_cyc(6);
        cfg_update_i = 1'b0;
        chk("start_ws_en", 32'(ws_en_o), 1);

        // Mid-frame update ds=7 wn=3, applied at the next frame boundary
        wait_cyc(75);
        upd(5'd7, 4'd3);
        push_fs(102, 5'd7, 4'd3);
        push_fs(134, 5'd7, 4'd3);
        wait_cyc(76);
        cfg_update_i = 1'b0;
        chk("pend_busy", 32'(busy_o), 1);
        chk("pend_ds_old", 32'(ws_data_size_o), 15);

        // Switch to ds=7 wn=1, then stop at bit 3 of word 0
        wait_cyc(140);
        upd(5'd7, 4'd1);
        push_fs(166, 5'd7, 4'd1);
        wait_cyc(141);
        cfg_update_i = 1'b0;
        wait_cyc(169);
        cfg_en_i = 1'b0;
        fall_q.push_back(182);
        wait_cyc(170);
        chk("drain_busy", 32'(busy_o), 1);
        chk("drain_ws_en", 32'(ws_en_o), 1);
        wait_cyc(183);
        chk("idle_busy", 32'(busy_o), 0);

        // Two updates in one frame: overwrite flagged, second value applied
        wait_cyc(185);
        cfg_en_i = 1'b1;
        push_fs(186, 5'd7, 4'd1);
        wait_cyc(188);
        upd(5'd3, 4'd1);
        wait_cyc(189);
        cfg_update_i = 1'b0;
        wait_cyc(190);
        upd(5'd1, 4'd1);
        push_fs(202, 5'd1, 4'd1);
        wait_cyc(191);
        cfg_update_i = 1'b0;
        chk("ovr_set", 32'(upd_ovr_o), 1);
        chk("ovr_busy", 32'(busy_o), 1);
        wait_cyc(202);
        cfg_clr_i = 1'b1;
        cfg_en_i  = 1'b0;
        fall_q.push_back(206);
        wait_cyc(203);
        cfg_clr_i = 1'b0;
        chk("ovr_clr", 32'(upd_ovr_o), 0);
        chk("drain2_busy", 32'(busy_o), 1);
        wait_cyc(207);
        chk("idle2_ds", 32'(ws_data_size_o), 1);
        chk("idle2_busy", 32'(busy_o), 0);

        // Word count clamp, applied directly while idle
        wait_cyc(210);
        upd(5'd5, 4'd12);
        wait_cyc(211);
        cfg_update_i = 1'b0;
        chk("clamp_wn", 32'(ws_word_num_o), 7);
        chk("clamp_ds", 32'(ws_data_size_o), 5);
        chk("clamp_busy", 32'(busy_o), 0);
        chk("clamp_ws_en", 32'(ws_en_o), 0);

        // Asynchronous reset mid-frame with an update pending
        wait_cyc(215);
        cfg_en_i = 1'b1;
        push_fs(216, 5'd5, 4'd7);
        wait_cyc(218);
        upd(5'd2, 4'd2);
        wait_cyc(219);
        cfg_update_i = 1'b0;
        chk("pre_rst_busy", 32'(busy_o), 1);
        wait_cyc(225);
        #2;
        rstn_i   = 1'b0;
        cfg_en_i = 1'b0;
        fall_q.push_back(226);
        #1;
        chk("arst_ws_en", 32'(ws_en_o), 0);
        chk("arst_ds", 32'(ws_data_size_o), 0);
        chk("arst_wn", 32'(ws_word_num_o), 0);
        chk("arst_fs", 32'(frame_start_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_ovr", 32'(upd_ovr_o), 0);
        chk("arst_fcnt", 32'(frame_cnt_o), 0);
        wait_cyc(228);
        rstn_i = 1'b1;

        // One-cycle frames for the frame counter
        wait_cyc(230);
        fs_mon_en = 1'b0;
        upd(5'd0, 4'd0);
        cfg_en_i = 1'b1;
        wait_cyc(231);
        cfg_update_i = 1'b0;
        wait_cyc(230 + NFRM);
        cfg_en_i = 1'b0;
        fall_q.push_back(231 + NFRM);
        wait_cyc(232 + NFRM);
        chk("fcnt", 32'(frame_cnt_o), FC_EXP);
        chk("fcnt_ws_en", 32'(ws_en_o), 0);

        wait_cyc(236 + NFRM);
        chk("fs_q_empty", fs_q.size(), 0);
        chk("fall_q_empty", fall_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_ws_ctrl.md
I2S_WS_CTRL -- requirements
Module: i2s_ws_ctrl

Interface
REQ-001 SHALL have port sck_i  in  1  I2S serial clock; all logic on rising edge.
REQ-002 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cfg_en_i  in  1  run request, level, sck_i domain.
REQ-004 SHALL have port cfg_update_i  in  1  one-cycle pulse; loads new frame configuration.
REQ-005 SHALL have port cfg_data_size_i  in  5  bits per word minus 1.
REQ-006 SHALL have port cfg_word_num_i  in  4  words per frame minus 1.
REQ-007 SHALL have port cfg_clr_i  in  1  pulse; clears upd_ovr_o.
REQ-008 SHALL have port ws_en_o  out  1  enable to WS generator.
REQ-009 SHALL have port ws_data_size_o  out  5  active data size to WS generator.
REQ-010 SHALL have port ws_word_num_o  out  4  active word count to WS generator.
REQ-011 SHALL have port frame_start_o  out  1  high during first bit cycle of each frame.
REQ-012 SHALL have port busy_o  out  1  update pending or stop draining.
REQ-013 SHALL have port upd_ovr_o  out  1  sticky: update overwritten before it was applied.
REQ-014 SHALL have port frame_cnt_o  out  16  completed-frame count.

Function
REQ-015 SHALL hold a shadow config (ds_sh, wn_sh), an active config (driving ws_*_o), and a pend flag.
REQ-016 SHALL clamp cfg_word_num_i values 8..15 to 7 when loading the shadow.
REQ-017 SHALL mirror the generator counters:
- bit_cnt (5 b) and word_cnt (3 b) advance only while ws_en_o=1.
- At bit_cnt==ds_act: bit_cnt->0; word_cnt->0 if word_cnt==wn_act, else +1.
- Otherwise bit_cnt+1.
REQ-018 SHALL define last = ws_en_o && bit_cnt==ds_act && word_cnt==wn_act (combinational).
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN; ws_en_o=1 in RUN and DRAIN only.
REQ-020 In IDLE, cfg_update_i SHALL load shadow and active together, without setting pend.
REQ-021 IDLE->RUN SHALL occur on the edge where cfg_en_i=1; counters are 0 and ws_en_o=1 from the next cycle.
- If cfg_update_i occurs on the same edge, the new values are active.
REQ-022 In RUN/DRAIN, cfg_update_i SHALL load shadow and set pend.
- If pend is already 1 and not being applied that edge, upd_ovr_o SHALL set.
REQ-023 On an edge with last=1 and pend=1, active SHALL take shadow and pend SHALL clear.
- If cfg_update_i arrives on the same edge, the old shadow is applied and the new value is re-pended.
REQ-024 RUN->DRAIN SHALL occur on an edge where cfg_en_i=0 and last=0.
REQ-025 RUN->IDLE SHALL occur on an edge where cfg_en_i=0 and last=1.
REQ-026 DRAIN->RUN SHALL occur on an edge where cfg_en_i=1, without a counter disturbance.
REQ-027 DRAIN->IDLE SHALL occur on an edge where last=1.
- ws_en_o falls on that edge; pending config is applied; counters are 0.
REQ-028 frame_start_o SHALL equal ws_en_o && bit_cnt==0 && word_cnt==0.
REQ-029 busy_o SHALL equal pend OR (state==DRAIN).
REQ-030 cfg_clr_i SHALL clear upd_ovr_o; a set on the same edge SHALL win.

Reset
REQ-031 On rstn_i low, the block SHALL enter IDLE.
- ws_en_o=0, ws_data_size_o=0, ws_word_num_o=0, shadow=0, counters=0.
- pend=0, upd_ovr_o=0, frame_cnt_o=0; hence frame_start_o=0, busy_o=0.
REQ-032 Reset mid-frame SHALL drop ws_en_o immediately; no drain is performed.

Configuration
REQ-033 Macro I2S_WS_CTRL_FRAME_CNT_EN defined: frame_cnt_o SHALL increment on every edge with last=1, wrapping 0xFFFF->0.
REQ-034 Macro undefined: frame_cnt_o SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-035 Reset, update ds=15 wn=1, cfg_en_i=1 -> ws_en_o=1 next cycle; frame_start_o every 32 cycles.
REQ-036 RUN ds=15 wn=1, update ds=7 wn=3 mid-frame -> busy_o=1, old frame completes, next frame 32 cycles with ds=7, busy_o=0.
REQ-037 cfg_en_i=0 at bit 3 of word 0 (ds=7, wn=1) -> DRAIN, ws_en_o falls exactly after bit 7 of word 1.
REQ-038 Two updates in one frame -> upd_ovr_o=1, second value applied; cfg_clr_i -> upd_ovr_o=0.
REQ-039 wn=12 requested -> ws_word_num_o=7.
REQ-040 With macro defined: 70000 frames -> frame_cnt_o=4464; rstn_i low mid-frame -> all outputs 0 asynchronously.
